// File: rtl/led_blink_pkg.sv
// Shared types and default constants for the multi-channel LED blinker.
package led_blink_pkg;

  // Default build-time configuration: three LEDs, 2.4 Hz blink at 48 MHz.
  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_CNT_W        = 25;
  localparam int DEF_PCNT_W       = 8;
  localparam int DEF_DEFAULT_HALF = 10_000_000;

  // Per-channel operating mode, encoded to match the 2-bit cfg_mode field.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } blink_mode_e;

  // A channel is "active" whenever its counter is running.
  function automatic logic isActive(input blink_mode_e m);
    return (m == MODE_BLINK) || (m == MODE_PULSE);
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration write port and LED status bundle for led_blink_ctrl.
interface led_blink_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 25,
  parameter int PCNT_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_half;
  logic [PCNT_W-1:0] cfg_count;
  logic              sync;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] done;
  logic              busy;

  // Controller side: drives configuration, observes LEDs.
  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count, sync,
    input  led, done, busy
  );

  // LED driver side: receives configuration, drives LEDs.
  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count, sync,
    output led, done, busy
  );
endinterface

// File: rtl/blink_channel.sv
// One LED channel: mode register, half-period counter, phase bit and
// remaining-pulse counter, with registered led/done outputs.
module blink_channel
  import led_blink_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PCNT_W       = DEF_PCNT_W,
  parameter int DEFAULT_HALF = DEF_DEFAULT_HALF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  blink_mode_e       mode_i,
  input  logic [CNT_W-1:0]  half_i,
  input  logic [PCNT_W-1:0] count_i,
  input  logic              sync_i,
  output logic              led_o,
  output logic              done_o,
  output logic              active_o
);

  blink_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0]  half_q, half_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [PCNT_W-1:0] remain_q, remain_d;
  logic              led_q, led_d;
  logic              done_q, done_d;
  logic              atWrap;

  // The counter wraps on half-1 so a full period is exactly 2*half cycles.
  assign atWrap = (cnt_q == (half_q - CNT_W'(1)));

  // Next-state selection: a write beats sync, and sync beats a terminal count.
  always_comb begin
    mode_d   = mode_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (we_i) begin
      mode_d   = mode_i;
      half_d   = (half_i == '0) ? CNT_W'(1) : half_i;
      cnt_d    = '0;
      phase_d  = 1'b1;
      remain_d = count_i;
      if ((mode_i == MODE_PULSE) && (count_i == '0)) begin
        mode_d = MODE_OFF;
        done_d = 1'b1;
      end
    end else if (isActive(mode_q)) begin
      if (sync_i) begin
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (atWrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        if ((mode_q == MODE_PULSE) && phase_q) begin
          remain_d = remain_q - PCNT_W'(1);
          if (remain_q <= PCNT_W'(1)) begin
            remain_d = '0;
            mode_d   = MODE_OFF;
            done_d   = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // The LED level is derived from the next state so it can be registered.
  always_comb begin
    led_d = phase_d;
    case (mode_d)
      MODE_OFF: led_d = 1'b0;
      MODE_ON:  led_d = 1'b1;
      default:  led_d = phase_d;
    endcase
  end

  // State and output registers; reset reproduces the legacy free-running blinker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_BLINK;
      half_q   <= CNT_W'(DEFAULT_HALF);
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      remain_q <= '0;
      led_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign led_o    = led_q;
  assign done_o   = done_q;
  assign active_o = isActive(mode_q);

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: decodes configuration writes to channels and
// aggregates per-channel activity into busy.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_DEFAULT_HALF,
  parameter int PCNT_W       = DEF_PCNT_W
) (
  input logic              clk,
  input logic              reset_n,
  led_blink_ctrl_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] chWe;
  logic [NUM_CH-1:0] chActive;
  logic [NUM_CH-1:0] ledVec;
  logic [NUM_CH-1:0] doneVec;

  // One channel per LED; addresses beyond NUM_CH match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign chWe[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    blink_channel #(
      .CNT_W        (CNT_W),
      .PCNT_W       (PCNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_channel (
      .clk      (clk),
      .reset_n  (reset_n),
      .we_i     (chWe[i]),
      .mode_i   (blink_mode_e'(bus.cfg_mode)),
      .half_i   (bus.cfg_half),
      .count_i  (bus.cfg_count),
      .sync_i   (bus.sync),
      .led_o    (ledVec[i]),
      .done_o   (doneVec[i]),
      .active_o (chActive[i])
    );
  end

  assign bus.led  = ledVec;
  assign bus.done = doneVec;
  assign bus.busy = |chActive;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed testbench for led_blink_ctrl with a short default half-period.
module tb_led_blink_ctrl;
  import led_blink_pkg::*;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 25;
  localparam int PCNT_W   = 8;
  localparam int DEF_HALF = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   compareCount  = 0;
  int   mismatchCount = 0;

  led_blink_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus ();

  led_blink_ctrl #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEF_HALF),
    .PCNT_W       (PCNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running 100 MHz-style clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] expLed,
                          input logic [2:0] expDone, input logic expBusy);
    checkOutput({tag, "_led"},  32'(bus.led),  32'(expLed));
    checkOutput({tag, "_done"}, 32'(bus.done), 32'(expDone));
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(expBusy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] ch, input blink_mode_e mode,
                               input logic [CNT_W-1:0] half, input logic [PCNT_W-1:0] count,
                               input logic syncIn);
    bus.cfg_we    = we;
    bus.cfg_ch    = ch;
    bus.cfg_mode  = mode;
    bus.cfg_half  = half;
    bus.cfg_count = count;
    bus.sync      = syncIn;
    tick();
    bus.cfg_we = 1'b0;
    bus.sync   = 1'b0;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    #1;
    checkAll("reset", 3'b111, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence; each check happens 1 time unit after a rising edge.
  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_half  = '0;
    bus.cfg_count = '0;
    bus.sync      = 1'b0;
    #2;

    // Reset default: every channel blinks with half = 4.
    resetDut();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkAll("def_blink", (k < 4 || k == 8) ? 3'b111 : 3'b000, 3'b000, 1'b1);
    end

    // ch1 BLINK half 3, then sync five cycles later realigns all channels.
    applyStimulus(1'b1, 2'd1, MODE_BLINK, 25'd3, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checkOutput("sync_pre_led1", 32'(bus.led[1]), 32'(k < 3));
    end
    applyStimulus(1'b0, 2'd0, MODE_OFF, 25'd0, 8'd0, 1'b1);
    checkAll("sync_edge", 3'b111, 3'b000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("sync_post_led", 32'(bus.led), (k == 3) ? 32'h5 : 32'h7);
    end

    // ch2 PULSE half 2 count 3: 1100 x3, done on the third falling edge.
    resetDut();
    applyStimulus(1'b1, 2'd2, MODE_PULSE, 25'd2, 8'd3, 1'b0);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick();
      checkOutput("pulse_led2", 32'(bus.led[2]), 32'((k < 10) && ((k % 4) < 2)));
      checkOutput("pulse_done", 32'(bus.done), (k == 10) ? 32'h4 : 32'h0);
      checkOutput("pulse_busy", 32'(bus.busy), 32'h1);
    end

    // ch0 OFF, ON, then BLINK with half 0 saturating to 1.
    applyStimulus(1'b1, 2'd0, MODE_OFF, 25'd7, 8'd0, 1'b0);
    checkOutput("off_led0", 32'(bus.led[0]), 32'h0);
    applyStimulus(1'b1, 2'd0, MODE_ON, 25'd7, 8'd0, 1'b0);
    checkOutput("on_led0", 32'(bus.led[0]), 32'h1);
    applyStimulus(1'b1, 2'd0, MODE_BLINK, 25'd0, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checkOutput("half0_led0", 32'(bus.led[0]), 32'((k % 2) == 0));
    end

    // PULSE with count 0 ends immediately with a single done pulse.
    applyStimulus(1'b1, 2'd2, MODE_PULSE, 25'd5, 8'd0, 1'b0);
    checkOutput("cnt0_led2", 32'(bus.led[2]), 32'h0);
    checkOutput("cnt0_done", 32'(bus.done), 32'h4);
    tick();
    checkOutput("cnt0_done_clr", 32'(bus.done), 32'h0);
    checkOutput("cnt0_led2_hold", 32'(bus.led[2]), 32'h0);

    // Write landing on the terminal-count edge overrides it.
    applyStimulus(1'b1, 2'd2, MODE_PULSE, 25'd1, 8'd1, 1'b0);
    checkOutput("term_pre_led2", 32'(bus.led[2]), 32'h1);
    applyStimulus(1'b1, 2'd2, MODE_BLINK, 25'd2, 8'd0, 1'b0);
    checkOutput("term_wr_done", 32'(bus.done), 32'h0);
    checkOutput("term_wr_led2", 32'(bus.led[2]), 32'h1);
    tick();
    checkOutput("term_next_led2", 32'(bus.led[2]), 32'h1);
    checkOutput("term_next_done", 32'(bus.done), 32'h0);
    tick();
    checkOutput("term_toggle_led2", 32'(bus.led[2]), 32'h0);

    // No channel blinking leaves busy low.
    applyStimulus(1'b1, 2'd0, MODE_OFF, 25'd1, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, MODE_ON, 25'd1, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'd2, MODE_OFF, 25'd1, 8'd0, 1'b0);
    checkAll("all_idle", 3'b010, 3'b000, 1'b0);

    // Asynchronous reset mid-PULSE with two pulses left.
    applyStimulus(1'b1, 2'd2, MODE_PULSE, 25'd2, 8'd3, 1'b0);
    checkAll("pulse_start", 3'b110, 3'b000, 1'b1);
    tick();
    tick();
    checkOutput("mid_pulse_led", 32'(bus.led), 32'h2);
    reset_n = 1'b0;
    #1;
    checkAll("async_reset", 3'b111, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Out-of-range channel write is ignored; default blink continues.
    applyStimulus(1'b1, 2'd3, MODE_OFF, 25'd1, 8'd0, 1'b0);
    checkAll("oor_e1", 3'b111, 3'b000, 1'b1);
    tick();
    tick();
    checkAll("oor_e3", 3'b111, 3'b000, 1'b1);
    tick();
    checkAll("oor_e4", 3'b000, 3'b000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
